// File: rtl/online_pkg.sv
// Shared constants, FSM state type and 7-segment glyph table for the UART
// alphabet-stream receiver.
package online_pkg;

  localparam logic [7:0] ASCII_A   = 8'h41;
  localparam logic [7:0] ASCII_Z   = 8'h5A;
  localparam int         ALPHA_LEN = 26;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    DRAIN
  } rx_state_t;

  // Active-high segments, a..g on bits 0..6; entry 15 first so index n selects digit n.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] next_letter(input logic [7:0] b);
    return (b == ASCII_Z) ? ASCII_A : b + 8'd1;
  endfunction

endpackage

// File: rtl/online_rx_hex7seg.sv
// Combinational 4-bit nibble to 7-segment glyph decoder.
// Zero latency; no flow control.
module hex7seg
  import online_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_GLYPH[i_nibble];

endmodule

// File: rtl/online_rx.sv
// UART receive consumer checking the cyclic A..Z stream; one pop per 3 cycles.
// Optional hex display of last_char enabled by ONLINE_RX_SEG_EN.
module online_rx
  import online_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxready,
  input  logic [7:0]       rxdata,
  output logic             rxclk,
  output logic [7:0]       last_char,
  output logic             byte_valid,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
`ifdef ONLINE_RX_SEG_EN
  ,
  output logic [7:0]       ss1,
  output logic [7:0]       ss0
`endif
);

  localparam logic [3:0] LC = 4'(LOCK_COUNT);

  rx_state_t        r_state;
  rx_state_t        w_next_state;
  logic             w_capture;
  logic             r_ack;
  logic [7:0]       r_last;
  logic [7:0]       r_expected;
  logic [3:0]       r_run;
  logic [ERR_W-1:0] r_err;

  logic             w_is_letter;
  logic             w_err_inc;
  logic [3:0]       w_run_nxt;
  logic [7:0]       w_exp_nxt;

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (rxready) begin
          w_capture    = 1'b1;
          w_next_state = ACK;
        end
      end
      ACK:     w_next_state = DRAIN;
      DRAIN:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Sequence checker evaluated on the byte currently presented by the UART.
  always_comb begin
    w_is_letter = (rxdata >= ASCII_A) && (rxdata <= ASCII_Z);
    w_err_inc   = 1'b0;
    w_run_nxt   = r_run;
    w_exp_nxt   = r_expected;
    if (!w_is_letter) begin
      w_err_inc = 1'b1;
      w_run_nxt = 4'd0;
    end else if (rxdata == r_expected) begin
      w_run_nxt = (r_run >= LC) ? LC : r_run + 4'd1;
      w_exp_nxt = next_letter(rxdata);
    end else begin
      w_err_inc = (r_run != 4'd0);
      w_run_nxt = 4'd1;
      w_exp_nxt = next_letter(rxdata);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ack      <= 1'b0;
      r_last     <= 8'h00;
      r_expected <= ASCII_A;
      r_run      <= 4'd0;
      r_err      <= '0;
    end else begin
      r_state <= w_next_state;
      r_ack   <= w_capture;
      if (w_capture) begin
        r_last     <= rxdata;
        r_expected <= w_exp_nxt;
        r_run      <= w_run_nxt;
        if (w_err_inc && (r_err != {ERR_W{1'b1}}))
          r_err <= r_err + 1'b1;
      end
    end
  end

  assign rxclk      = r_ack;
  assign byte_valid = r_ack;
  assign last_char  = r_last;
  assign locked     = (r_run >= LC);
  assign err_count  = r_err;

`ifdef ONLINE_RX_SEG_EN
  logic [6:0] w_seg_hi;
  logic [6:0] w_seg_lo;
  logic [7:0] r_ss1;
  logic [7:0] r_ss0;

  hex7seg u_hex_hi (.i_nibble(r_last[7:4]), .o_seg(w_seg_hi));
  hex7seg u_hex_lo (.i_nibble(r_last[3:0]), .o_seg(w_seg_lo));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ss1 <= {1'b0, SEG_GLYPH[0]};
      r_ss0 <= {1'b0, SEG_GLYPH[0]};
    end else begin
      r_ss1 <= {locked, w_seg_hi};
      r_ss0 <= {locked, w_seg_lo};
    end
  end

  assign ss1 = r_ss1;
  assign ss0 = r_ss0;
`endif

endmodule

// File: tb/tb_online_rx.sv
// Scoreboard bench for online_rx: directed byte streams with hand-computed
// expected last_char / locked / err_count per byte_valid pulse.
module tb_online_rx;

  localparam int ERR_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rxready = 1'b0;
  logic [7:0]       rxdata = 8'h00;
  logic             rxclk;
  logic [7:0]       last_char;
  logic             byte_valid;
  logic             locked;
  logic [ERR_W-1:0] err_count;
`ifdef ONLINE_RX_SEG_EN
  logic [7:0]       ss1;
  logic [7:0]       ss0;
`endif

  online_rx #(.LOCK_COUNT(4), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxready   (rxready),
    .rxdata    (rxdata),
    .rxclk     (rxclk),
    .last_char (last_char),
    .byte_valid(byte_valid),
    .locked    (locked),
    .err_count (err_count)
`ifdef ONLINE_RX_SEG_EN
    ,
    .ss1       (ss1),
    .ss0       (ss0)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       ch;
    logic             lk;
    logic [ERR_W-1:0] err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   prev_bv = -1;
  logic gap_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every byte_valid pulse.
  always @(negedge clk) begin
    if (rxclk || byte_valid)
      check("rxclk_eq_byte_valid", int'(rxclk), int'(byte_valid));
    if (byte_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte_valid: got last_char 0x%0h, expected no pulse", last_char);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("last_char", int'(last_char), int'(e.ch));
        check("locked", int'(locked), int'(e.lk));
        check("err_count", int'(err_count), int'(e.err));
      end
      if (gap_chk && prev_bv >= 0)
        check("pop_spacing", cyc - prev_bv, 3);
      prev_bv = cyc;
    end
  end

  task automatic do_reset();
    reset   = 1'b1;
    rxready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Presents one byte and returns #1 into its ACK cycle, leaving rxready high.
  task automatic send(input logic [7:0] b, input logic lk, input logic [ERR_W-1:0] err);
    exp_t e;
    bit   seen;
    e.ch  = b;
    e.lk  = lk;
    e.err = err;
    q.push_back(e);
    rxdata  = b;
    rxready = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (rxclk) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pop_timeout: got no rxclk within 8 cycles, expected a pop of 0x%0h", b);
    end
  endtask

  logic [7:0] seq3  [9] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h47, 8'h48, 8'h49, 8'h4A};
  logic       lk3   [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 1};
  logic [3:0] err3  [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
  logic [7:0] seq4  [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h30, 8'h45};
  logic       lk4   [6] = '{0, 0, 0, 1, 0, 0};
  logic [3:0] err4  [6] = '{0, 0, 0, 0, 1, 1};

  initial begin
    // Idle after reset: no strobes, reset values held.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_rxclk", int'(rxclk), 0);
      check("idle_byte_valid", int'(byte_valid), 0);
    end
    check("reset_last_char", int'(last_char), 8'h00);
    check("reset_err_count", int'(err_count), 0);
    check("reset_locked", int'(locked), 0);
`ifdef ONLINE_RX_SEG_EN
    check("reset_ss1", int'(ss1), 8'h3F);
    check("reset_ss0", int'(ss0), 8'h3F);
`endif
    @(posedge clk);
    #1;

    // Continuous alphabet A..Z, A..D with wrap.
    gap_chk = 1'b1;
    prev_bv = -1;
    for (int i = 0; i < 30; i++)
      send(8'h41 + 8'(i % 26), (i >= 3), 4'd0);
    rxready = 1'b0;
    repeat (3) @(posedge clk);
    gap_chk = 1'b0;
    @(negedge clk);
    check("alpha_final_last_char", int'(last_char), 8'h44);
    check("alpha_final_err", int'(err_count), 0);

    // Skipped letter breaks lock, then relock.
    do_reset();
    for (int i = 0; i < 9; i++) send(seq3[i], lk3[i], err3[i]);
    rxready = 1'b0;

    // Non-letter resets the run without moving expected.
    do_reset();
    for (int i = 0; i < 6; i++) send(seq4[i], lk4[i], err4[i]);
    rxready = 1'b0;

    // Reset during the ACK cycle of Q.
    do_reset();
    send(8'h51, 1'b0, 4'd0);
    reset   = 1'b1;
    rxready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    check("ack_reset_rxclk", int'(rxclk), 0);
    check("ack_reset_last_char", int'(last_char), 8'h00);
    check("ack_reset_err", int'(err_count), 0);
    @(posedge clk);
    #1;
    send(8'h58, 1'b0, 4'd0);
    rxready = 1'b0;

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 20; i++)
      send(8'h30, 1'b0, (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    rxready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sat_err_count", int'(err_count), 15);
`ifdef ONLINE_RX_SEG_EN
    check("sat_ss1", int'(ss1), 8'h4F);
    check("sat_ss0", int'(ss0), 8'h3F);
`endif

    repeat (4) @(posedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
